// File: rtl/usbfs_endp_rx.sv
// usbfs_endp_rx
// Bulk/interrupt OUT endpoint drain. It takes one complete packet at a time
// from the USB packet receiver, reads the payload out of the receive buffer
// byte by byte, and presents it as a valid/ready byte stream with a
// last-byte flag.
//
// Ports
//   i_clk, i_rst       clock (rising edge) and synchronous active-high reset
//   i_erValid          receiver holds a complete OUT packet
//   o_erReady          endpoint can take a packet (low makes the receiver NAK)
//   o_erStall          endpoint halted (never halted here)
//   i_erRdNBytes       payload length of the offered packet
//   o_erRdEn/o_erRdIdx receive-buffer read strobe and byte index
//   i_erRdByte         receive-buffer data, one cycle after o_erRdEn
//   o_valid/i_ready    output stream handshake
//   o_data/o_last      stream byte and end-of-packet flag
module usbfs_endp_rx #(
  parameter int MAX_PKT = 8,
  localparam int NBYTES_W = $clog2(MAX_PKT + 1),
  localparam int IDX_W = $clog2(MAX_PKT)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_erValid,
  output logic                o_erReady,
  output logic                o_erStall,
  input  logic [NBYTES_W-1:0] i_erRdNBytes,
  output logic                o_erRdEn,
  output logic [IDX_W-1:0]    o_erRdIdx,
  input  logic [7:0]          i_erRdByte,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [7:0]          o_data,
  output logic                o_last
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t              state_q;
  logic [NBYTES_W-1:0] n_bytes_q;
  logic [NBYTES_W-1:0] issued_q;
  logic [NBYTES_W-1:0] popped_q;
  logic                inflight_q;
  logic [7:0]          fifo_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  logic                er_accepted;
  logic                pop;
  logic [2:0]          occ_next;
  logic [NBYTES_W-1:0] len_clamped;

  assign o_erReady   = (state_q == IDLE);
  assign o_erStall   = 1'b0;
  assign er_accepted = i_erValid && o_erReady;

  assign o_valid = (count_q != 2'd0);
  assign pop     = o_valid && i_ready;
  assign o_data  = o_valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign o_last  = o_valid && (popped_q == n_bytes_q - NBYTES_W'(1));

  // FIFO occupancy after this cycle's write (the byte already in flight)
  // and pop. A new read is only issued if its byte is guaranteed a slot
  // when it lands, so the two-entry FIFO can never overflow.
  assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign o_erRdEn  = (state_q == DRAIN) && (issued_q < n_bytes_q) && (occ_next < 3'd2);
  assign o_erRdIdx = issued_q[IDX_W-1:0];

  // Oversized lengths are truncated to what the buffer can hold.
  assign len_clamped = (i_erRdNBytes > NBYTES_W'(MAX_PKT)) ? NBYTES_W'(MAX_PKT) : i_erRdNBytes;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      n_bytes_q  <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= 8'h00;
      fifo_q[1]  <= 8'h00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= o_erRdEn;

      if (o_erRdEn) begin
        issued_q <= issued_q + NBYTES_W'(1);
      end
      if (pop) begin
        popped_q <= popped_q + NBYTES_W'(1);
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= i_erRdByte;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      count_q <= occ_next[1:0];

      // Acceptance only happens in IDLE, where no read or pop can be
      // active, so the counter clears here never race the increments.
      case (state_q)
        IDLE: begin
          if (er_accepted) begin
            n_bytes_q <= len_clamped;
            issued_q  <= '0;
            popped_q  <= '0;
            if (len_clamped != '0) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && o_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usbfs_endp_rx.sv
// tb_usbfs_endp_rx
// Self-checking bench for usbfs_endp_rx. A per-cycle sampler emulates the
// receive buffer and logs stream beats, buffer reads and handshakes; each
// test task compares those logs against the expected packet behaviour.
module tb_usbfs_endp_rx;

  localparam int MAX_PKT = 8;
  localparam int NB_W = $clog2(MAX_PKT + 1);
  localparam int IX_W = $clog2(MAX_PKT);

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_erValid;
  logic            o_erReady;
  logic            o_erStall;
  logic [NB_W-1:0] i_erRdNBytes;
  logic            o_erRdEn;
  logic [IX_W-1:0] o_erRdIdx;
  logic [7:0]      i_erRdByte;
  logic            o_valid;
  logic            i_ready;
  logic [7:0]      o_data;
  logic            o_last;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Receive buffer contents and activity log for the current packet
  logic [7:0] pkt [MAX_PKT];
  logic [7:0] out_data [$];
  bit         out_last [$];
  int         out_cyc [$];
  int         rd_idx [$];
  int         rd_cyc [$];
  int         acc_cyc [$];
  bit         rdy_hist [$];
  int         cyc;
  int         stall_viol;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  bit         rd_pend;
  int         pend_idx;

  usbfs_endp_rx #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_erValid    (i_erValid),
    .o_erReady    (o_erReady),
    .o_erStall    (o_erStall),
    .i_erRdNBytes (i_erRdNBytes),
    .o_erRdEn     (o_erRdEn),
    .o_erRdIdx    (o_erRdIdx),
    .i_erRdByte   (i_erRdByte),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock cycle: serve last cycle's buffer read, sample and log the
  // outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    i_erRdByte = rd_pend ? pkt[pend_idx] : 8'($urandom);
    #1;
    rdy_hist.push_back(o_erReady);
    if (prev_stall && (!o_valid || o_data !== prev_data || o_last !== prev_last)) stall_viol++;
    prev_stall = o_valid && !i_ready && !i_rst;
    prev_data  = o_data;
    prev_last  = o_last;
    if (o_valid && i_ready && !i_rst) begin
      out_data.push_back(o_data);
      out_last.push_back(o_last);
      out_cyc.push_back(cyc);
    end
    if (o_erRdEn && !i_rst) begin
      rd_idx.push_back(int'(o_erRdIdx));
      rd_cyc.push_back(cyc);
    end
    if (i_erValid && o_erReady && !i_rst) acc_cyc.push_back(cyc);
    rd_pend  = o_erRdEn && !i_rst;
    pend_idx = int'(o_erRdIdx);
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    out_data.delete(); out_last.delete(); out_cyc.delete();
    rd_idx.delete(); rd_cyc.delete(); acc_cyc.delete(); rdy_hist.delete();
    cyc = 0;
    stall_viol = 0;
    prev_stall = 1'b0;
  endtask

  task automatic fill_pkt();
    for (int i = 0; i < MAX_PKT; i++) pkt[i] = 8'($urandom);
  endtask

  // Present a packet for exactly one cycle; that cycle becomes cycle 0.
  task automatic offer(input int len);
    i_erValid    = 1'b1;
    i_erRdNBytes = NB_W'(len);
    tick();
    i_erValid    = 1'b0;
    i_erRdNBytes = NB_W'($urandom);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    vec_cnt++; if (o_erReady !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rst_ready got %b exp 1", o_erReady); end
    vec_cnt++; if (o_erStall !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_stall got %b exp 0", o_erStall); end
    vec_cnt++; if (o_erRdEn !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_rden got %b exp 0", o_erRdEn); end
    vec_cnt++; if (o_erRdIdx !== '0) begin miss_cnt++; $display("[TB] FAIL rst_idx got %0d exp 0", o_erRdIdx); end
    vec_cnt++; if (o_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_valid got %b exp 0", o_valid); end
    vec_cnt++; if (o_data !== 8'h00) begin miss_cnt++; $display("[TB] FAIL rst_data got %h exp 00", o_data); end
    vec_cnt++; if (o_last !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_last got %b exp 0", o_last); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_three_byte();
    int exp_b [3] = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) pkt[i] = 8'(exp_b[i]);
    i_ready = 1'b1;
    clear_log();
    offer(3);
    repeat (8) tick();
    vec_cnt++; if (acc_cyc.size() != 1) begin miss_cnt++; $display("[TB] FAIL t3_accepts got %0d exp 1", acc_cyc.size()); end
    vec_cnt++; if (rd_idx.size() != 3) begin miss_cnt++; $display("[TB] FAIL t3_rden_count got %0d exp 3", rd_idx.size()); end
    vec_cnt++; if (out_data.size() != 3) begin miss_cnt++; $display("[TB] FAIL t3_beats got %0d exp 3", out_data.size()); end
    for (int i = 0; i < 3 && i < rd_idx.size(); i++) begin
      vec_cnt++; if (rd_idx[i] != i || rd_cyc[i] != i + 1) begin miss_cnt++; $display("[TB] FAIL t3_rd%0d got idx %0d cyc %0d exp idx %0d cyc %0d", i, rd_idx[i], rd_cyc[i], i, i + 1); end
    end
    for (int i = 0; i < 3 && i < out_data.size(); i++) begin
      vec_cnt++;
      if (out_data[i] !== 8'(exp_b[i]) || out_cyc[i] != i + 3 || out_last[i] != (i == 2)) begin
        miss_cnt++;
        $display("[TB] FAIL t3_beat%0d got %h@%0d last %b exp %h@%0d last %b", i, out_data[i], out_cyc[i], out_last[i], 8'(exp_b[i]), i + 3, i == 2);
      end
    end
    vec_cnt++; if (rdy_hist[5] !== 1'b0) begin miss_cnt++; $display("[TB] FAIL t3_ready_c5 got %b exp 0", rdy_hist[5]); end
    vec_cnt++; if (rdy_hist[6] !== 1'b1) begin miss_cnt++; $display("[TB] FAIL t3_ready_c6 got %b exp 1", rdy_hist[6]); end
  endtask

  task automatic test_full_packet();
    fill_pkt();
    i_ready = 1'b1;
    clear_log();
    offer(MAX_PKT);
    repeat (MAX_PKT + 5) tick();
    vec_cnt++; if (rd_idx.size() != MAX_PKT) begin miss_cnt++; $display("[TB] FAIL full_rden_count got %0d exp %0d", rd_idx.size(), MAX_PKT); end
    vec_cnt++; if (out_data.size() != MAX_PKT) begin miss_cnt++; $display("[TB] FAIL full_beats got %0d exp %0d", out_data.size(), MAX_PKT); end
    for (int i = 0; i < rd_idx.size(); i++) begin
      vec_cnt++; if (rd_idx[i] != i) begin miss_cnt++; $display("[TB] FAIL full_idx%0d got %0d exp %0d", i, rd_idx[i], i); end
    end
    for (int i = 0; i < out_data.size() && i < MAX_PKT; i++) begin
      vec_cnt++;
      if (out_data[i] !== pkt[i] || out_cyc[i] != i + 3 || out_last[i] != (i == MAX_PKT - 1)) begin
        miss_cnt++;
        $display("[TB] FAIL full_beat%0d got %h@%0d last %b exp %h@%0d last %b", i, out_data[i], out_cyc[i], out_last[i], pkt[i], i + 3, i == MAX_PKT - 1);
      end
    end
  endtask

  task automatic test_zero_len();
    int not_ready;
    i_ready = 1'b1;
    clear_log();
    offer(0);
    repeat (6) tick();
    not_ready = 0;
    foreach (rdy_hist[i]) if (rdy_hist[i] !== 1'b1) not_ready++;
    vec_cnt++; if (acc_cyc.size() != 1) begin miss_cnt++; $display("[TB] FAIL zlp_accepts got %0d exp 1", acc_cyc.size()); end
    vec_cnt++; if (rd_idx.size() != 0) begin miss_cnt++; $display("[TB] FAIL zlp_rden got %0d exp 0", rd_idx.size()); end
    vec_cnt++; if (out_data.size() != 0) begin miss_cnt++; $display("[TB] FAIL zlp_beats got %0d exp 0", out_data.size()); end
    vec_cnt++; if (not_ready != 0) begin miss_cnt++; $display("[TB] FAIL zlp_ready_low_cycles got %0d exp 0", not_ready); end
  endtask

  task automatic test_backpressure();
    int early_rd;
    fill_pkt();
    i_ready = 1'b1;
    clear_log();
    offer(5);
    for (int k = 0; k < 40 && out_data.size() < 5; k++) begin
      i_ready = !(cyc >= 3 && cyc <= 7);
      tick();
    end
    i_ready = 1'b1;
    repeat (2) tick();
    vec_cnt++; if (out_data.size() != 5) begin miss_cnt++; $display("[TB] FAIL bp_beats got %0d exp 5", out_data.size()); end
    vec_cnt++; if (stall_viol != 0) begin miss_cnt++; $display("[TB] FAIL bp_hold_violations got %0d exp 0", stall_viol); end
    if (out_data.size() > 0) begin
      early_rd = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] < out_cyc[0]) early_rd++;
      vec_cnt++; if (out_cyc[0] != 8 || out_data[0] !== pkt[0]) begin miss_cnt++; $display("[TB] FAIL bp_first got %h@%0d exp %h@8", out_data[0], out_cyc[0], pkt[0]); end
      vec_cnt++; if (early_rd > 2) begin miss_cnt++; $display("[TB] FAIL bp_rden_before_pop got %0d exp <=2", early_rd); end
    end
    for (int i = 0; i < out_data.size() && i < 5; i++) begin
      vec_cnt++; if (out_data[i] !== pkt[i] || out_last[i] != (i == 4)) begin miss_cnt++; $display("[TB] FAIL bp_beat%0d got %h last %b exp %h last %b", i, out_data[i], out_last[i], pkt[i], i == 4); end
    end
  endtask

  task automatic test_busy_ignore();
    int busy_ready;
    fill_pkt();
    i_ready = 1'b0;
    clear_log();
    offer(4);
    for (int k = 1; k <= 6; k++) begin
      i_erValid    = 1'b1;
      i_erRdNBytes = NB_W'(2);
      tick();
    end
    i_erValid = 1'b0;
    i_ready   = 1'b1;
    for (int k = 0; k < 30 && out_data.size() < 4; k++) tick();
    repeat (2) tick();
    busy_ready = 0;
    for (int c = 1; c <= 6; c++) if (rdy_hist[c] !== 1'b0) busy_ready++;
    vec_cnt++; if (acc_cyc.size() != 1) begin miss_cnt++; $display("[TB] FAIL busy_accepts got %0d exp 1", acc_cyc.size()); end
    vec_cnt++; if (busy_ready != 0) begin miss_cnt++; $display("[TB] FAIL busy_ready_high_cycles got %0d exp 0", busy_ready); end
    vec_cnt++; if (out_data.size() != 4) begin miss_cnt++; $display("[TB] FAIL busy_beats got %0d exp 4", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 4; i++) begin
      vec_cnt++; if (out_data[i] !== pkt[i] || out_last[i] != (i == 3)) begin miss_cnt++; $display("[TB] FAIL busy_beat%0d got %h last %b exp %h last %b", i, out_data[i], out_last[i], pkt[i], i == 3); end
    end
  endtask

  task automatic test_reset_mid();
    fill_pkt();
    i_ready = 1'b1;
    clear_log();
    offer(5);
    for (int k = 0; k < 20 && out_data.size() < 2; k++) tick();
    vec_cnt++; if (out_data.size() != 2) begin miss_cnt++; $display("[TB] FAIL rmid_pops_before_reset got %0d exp 2", out_data.size()); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    vec_cnt++; if (o_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rmid_valid got %b exp 0", o_valid); end
    vec_cnt++; if (o_erReady !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rmid_ready got %b exp 1", o_erReady); end
    clear_log();
    repeat (3) tick();
    vec_cnt++; if (out_data.size() != 0 || rd_idx.size() != 0) begin miss_cnt++; $display("[TB] FAIL rmid_leftover got beats %0d reads %0d exp 0 0", out_data.size(), rd_idx.size()); end
    fill_pkt();
    clear_log();
    offer(3);
    repeat (8) tick();
    vec_cnt++; if (rd_idx.size() == 0 || rd_idx[0] != 0) begin miss_cnt++; $display("[TB] FAIL rmid_first_idx got reads %0d exp first idx 0", rd_idx.size()); end
    vec_cnt++; if (out_data.size() != 3) begin miss_cnt++; $display("[TB] FAIL rmid_beats got %0d exp 3", out_data.size()); end
    for (int i = 0; i < out_data.size() && i < 3; i++) begin
      vec_cnt++; if (out_data[i] !== pkt[i]) begin miss_cnt++; $display("[TB] FAIL rmid_beat%0d got %h exp %h", i, out_data[i], pkt[i]); end
    end
  endtask

  // Random lengths (including zero and oversize) under random backpressure.
  // Expected stream: the first min(len, MAX_PKT) buffer bytes, in order,
  // last flag on the final one, each index read exactly once.
  task automatic test_random();
    int len;
    int n;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(0, (1 << NB_W) - 1);
      n   = (len > MAX_PKT) ? MAX_PKT : len;
      fill_pkt();
      i_ready = 1'b1;
      clear_log();
      offer(len);
      for (int k = 0; k < 300 && (out_data.size() < n || k < 4); k++) begin
        i_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      i_ready = 1'b1;
      repeat (2) tick();
      vec_cnt++; if (out_data.size() != n) begin miss_cnt++; $display("[TB] FAIL rnd%0d_beats len %0d got %0d exp %0d", p, len, out_data.size(), n); end
      vec_cnt++; if (rd_idx.size() != n) begin miss_cnt++; $display("[TB] FAIL rnd%0d_reads len %0d got %0d exp %0d", p, len, rd_idx.size(), n); end
      vec_cnt++; if (stall_viol != 0) begin miss_cnt++; $display("[TB] FAIL rnd%0d_hold got %0d exp 0", p, stall_viol); end
      vec_cnt++; if (rdy_hist[rdy_hist.size() - 1] !== 1'b1) begin miss_cnt++; $display("[TB] FAIL rnd%0d_ready_end got 0 exp 1", p); end
      for (int i = 0; i < out_data.size() && i < n; i++) begin
        vec_cnt++; if (out_data[i] !== pkt[i] || out_last[i] != (i == n - 1)) begin miss_cnt++; $display("[TB] FAIL rnd%0d_beat%0d got %h last %b exp %h last %b", p, i, out_data[i], out_last[i], pkt[i], i == n - 1); end
      end
      for (int i = 0; i < rd_idx.size() && i < n; i++) begin
        vec_cnt++; if (rd_idx[i] != i) begin miss_cnt++; $display("[TB] FAIL rnd%0d_idx%0d got %0d exp %0d", p, i, rd_idx[i], i); end
      end
    end
  endtask

  initial begin
    i_rst        = 1'b1;
    i_erValid    = 1'b0;
    i_erRdNBytes = '0;
    i_erRdByte   = 8'h00;
    i_ready      = 1'b0;
    rd_pend      = 1'b0;
    pend_idx     = 0;
    for (int i = 0; i < MAX_PKT; i++) pkt[i] = 8'h00;
    clear_log();
    $display("[TB] starting usbfs_endp_rx bench");
    test_reset();
    test_three_byte();
    test_full_packet();
    test_zero_len();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/usbfs_endp_rx.md
USBFS_ENDP_RX -- requirements
Module: usbfs_endp_rx

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8: max packet payload in bytes; power of 2, >=2.
REQ-002 SHALL derive NBYTES_W = clog2(MAX_PKT+1) and IDX_W = clog2(MAX_PKT).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_erValid  input  1  packet receiver has a complete OUT data packet buffered.
REQ-007 o_erReady  output  1  endpoint can take a packet; low causes receiver to NAK.
REQ-008 o_erStall  output  1  endpoint halted; constant 0.
REQ-009 i_erRdNBytes  input  NBYTES_W  payload length of offered packet, valid with i_erValid.
REQ-010 o_erRdEn  output  1  read strobe to receive buffer.
REQ-011 o_erRdIdx  output  IDX_W  byte index being read.
REQ-012 i_erRdByte  input  8  buffer read data, valid the cycle after o_erRdEn.
REQ-013 o_valid  output  1  stream byte available.
REQ-014 i_ready  input  1  stream consumer accepts byte.
REQ-015 o_data  output  8  stream byte.
REQ-016 o_last  output  1  o_data is final byte of its packet.

Function
REQ-017 SHALL define er_accepted = i_erValid && o_erReady; pop = o_valid && i_ready.
REQ-018 SHALL have two states: IDLE, DRAIN; o_erReady = (state == IDLE).
REQ-019 On er_accepted: latch nBytes = min(i_erRdNBytes, MAX_PKT); clear issued/popped counters; go DRAIN if nBytes != 0, else stay IDLE (zero-length packet emits nothing).
REQ-020 SHALL never accept i_erValid in DRAIN; length input ignored there.
REQ-021 SHALL hold a 2-entry output FIFO and a 1-bit inflight_q = o_erRdEn registered.
REQ-022 In DRAIN, o_erRdEn = (issued < nBytes) && (count_q + inflight_q - pop) < 2; o_erRdEn = 0 in IDLE.
REQ-023 o_erRdIdx = issued[IDX_W-1:0]; issued increments by 1 per o_erRdEn; never exceeds nBytes.
REQ-024 When inflight_q, i_erRdByte SHALL be written to FIFO tail that cycle; visible at o_data no earlier than next cycle.
REQ-025 o_valid = (count_q != 0); o_data = FIFO head when o_valid, else 0.
REQ-026 o_data/o_last SHALL remain stable while o_valid && !i_ready.
REQ-027 o_last = o_valid && (popped == nBytes-1).
REQ-028 popped increments on each pop; pop with o_last SHALL move DRAIN->IDLE; o_erReady high next cycle.
REQ-029 Simultaneous FIFO write and pop SHALL keep count unchanged and preserve order.
REQ-030 Latency: er_accepted in cycle 0 -> o_erRdEn cycle 1 -> first o_valid cycle 3.
REQ-031 With i_ready held high, SHALL sustain one byte per cycle after first byte.
REQ-032 Counters SHALL be NBYTES_W wide so index MAX_PKT-1 -> count MAX_PKT does not wrap.

Reset
REQ-033 While i_rst high (sampled): state=IDLE, counters=0, FIFO empty, inflight_q=0, nBytes=0.
REQ-034 Reset values: o_erReady=1, o_erStall=0, o_erRdEn=0, o_erRdIdx=0, o_valid=0, o_data=0, o_last=0.
REQ-035 Reset mid-DRAIN SHALL discard buffered/in-flight bytes; no partial-packet output after reset.

Verification
REQ-036 3-byte packet A1,B2,C3, i_ready=1, accept cycle 0 -> o_erRdEn cycles 1-3 idx 0,1,2; o_valid cycles 3-5 data A1,B2,C3; o_last only cycle 5; o_erReady=1 cycle 6.
REQ-037 MAX_PKT=8, nBytes=8, i_ready=1 -> 8 contiguous beats, idx 0..7, o_last on 8th, exactly 8 rdEn.
REQ-038 i_erRdNBytes=0 accepted -> no o_erRdEn, no o_valid, o_erReady stays 1.
REQ-039 5-byte packet, i_ready low cycles 3-7 -> o_data held at byte 0, count<=2, at most 2 rdEn issued before first pop; all 5 bytes delivered in order.
REQ-040 i_erValid=1 during DRAIN -> o_erReady=0, packet not accepted, nBytes unchanged.
REQ-041 i_rst pulsed after 2 of 5 bytes popped -> next cycle o_valid=0, o_erReady=1; next packet read from idx 0.
